pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the architectural PC register and sequences each instruction through fetch, execute and PC update.
- Issues fetch requests to instruction memory and holds the fetched word stable for the datapath until the datapath signals completion.
- Applies the next-PC decision from the branch/next-PC unit: sequential PC+4, or a taken target.
- Drives HOLD to the next-PC unit so the PC freezes while an instruction is still in flight.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- ACK_TIMEOUT, 255, maximum cycles to wait for IMEM_ACK before flagging a fetch error; 8-bit counter width.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IMEM_REQ  out  1  fetch request; held high until acknowledged.
- IMEM_ADDR  out  32  fetch address; always equals PC.
- IMEM_ACK  in  1  fetch data valid this cycle.
- IMEM_DATA  in  32  fetched instruction word.
- INSTR  out  32  latched instruction presented to the datapath.
- INSTR_VALID  out  1  INSTR is valid and executing.
- EXEC_DONE  in  1  datapath has finished the current instruction; sampled only while INSTR_VALID=1.
- NEXT_PC  in  32  next-PC unit output (PC+4 or PC+IMM).
- HALT_REQ  in  1  stop after the current instruction retires.
- HOLD  out  1  freeze request to the next-PC unit.
- PC  out  32  current PC.
- ERR  out  1  sticky fault flag (misaligned target or fetch timeout).
- HALTED  out  1  sequencer is in the HALT state.

Behaviour:
- FSM states:
  - RESET_ST: entered on RST.
  - FETCH: IMEM_REQ=1.
  - EXEC: INSTR_VALID=1.
  - UPDATE: PC written.
  - HALT: terminal.
- Reset values: PC=RESET_VECTOR, INSTR=0, IMEM_REQ=0, INSTR_VALID=0, HOLD=1, ERR=0, HALTED=0, timeout counter=0, state=RESET_ST.
- RST has priority over every other input in every state, including mid-fetch and mid-exec. Any pending ACK is dropped.
- RESET_ST -> FETCH unconditionally on the next cycle.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC, HOLD=1.
  - On IMEM_ACK: INSTR<=IMEM_DATA, go to EXEC, clear the counter.
  - An ACK on the same edge that REQ first rises is accepted; zero-wait memory gives one cycle in FETCH.
  - Otherwise the counter increments. When the counter reaches ACK_TIMEOUT with no ACK: ERR<=1, go to HALT.
- EXEC:
  - INSTR_VALID=1, HOLD=1, INSTR stable.
  - On EXEC_DONE go to UPDATE.
  - EXEC_DONE in the same cycle INSTR_VALID first rises is honoured, giving a minimum one-cycle EXEC.
- UPDATE:
  - HOLD=0 and INSTR_VALID=0 for exactly one cycle.
  - PC<=NEXT_PC, unless NEXT_PC[1:0]!=0: then PC is unchanged, ERR<=1, go to HALT.
  - Otherwise, if HALT_REQ (sampled in EXEC or UPDATE) -> HALT; else -> FETCH.
- HALT:
  - HALTED=1, HOLD=1, IMEM_REQ=0, INSTR_VALID=0.
  - Only RST exits.
- Throughput: minimum 3 cycles per instruction (FETCH, EXEC, UPDATE).
- PC arithmetic is 32-bit modulo. NEXT_PC wrap from 32'hFFFF_FFFC to 0 is legal and not an error.
- ERR is sticky until RST.
- HALT_REQ asserted during FETCH is latched. The fetched instruction still executes and retires before halting.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- When defined:
  - Adds outputS RETIRED_CNT[31:0] and TAKEN_CNT[31:0], both reset to 0.
  - RETIRED_CNT increments on each UPDATE cycle that does not fault.
  - TAKEN_CNT increments on each such UPDATE where NEXT_PC != PC+4.
  - Both counters wrap at 2^32.
- When undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, zero-wait memory, NEXT_PC=PC+4, EXEC_DONE asserted immediately -> IMEM_ADDR sequence 0,4,8,12 with exactly 3 cycles between fetches; HOLD low only in UPDATE cycles.
- Taken branch: at PC=8, NEXT_PC=32'h40 -> next IMEM_ADDR=32'h40; with PC_SEQ_PERF_EN, TAKEN_CNT=1 and RETIRED_CNT=3 after that retire.
- Misaligned target: NEXT_PC=32'h42 in UPDATE -> PC stays at its old value, ERR=1, HALTED=1 next cycle, IMEM_REQ stays 0 thereafter.
- Fetch timeout with ACK_TIMEOUT=4: IMEM_ACK never asserted -> ERR=1 and HALTED=1 after 4 FETCH cycles; assert RST -> PC=RESET_VECTOR, ERR=0.
- Stall: ACK after 3 cycles, EXEC_DONE after 5 cycles -> INSTR equals the ACKed IMEM_DATA and stays stable all 5 EXEC cycles; PC unchanged until UPDATE.
- RST asserted mid-EXEC and HALT_REQ during FETCH -> RST: INSTR_VALID=0, PC=RESET_VECTOR next cycle. HALT_REQ: instruction retires, PC updates, then HALTED=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// PC sequencer: owns the PC and walks each instruction through FETCH -> EXEC -> UPDATE.
// Optional retire/taken performance counters are enabled by defining PC_SEQ_PERF_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          ACK_TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_ACK,
  input  logic [31:0] IMEM_DATA,
  output logic [31:0] INSTR,
  output logic        INSTR_VALID,
  input  logic        EXEC_DONE,
  input  logic [31:0] NEXT_PC,
  input  logic        HALT_REQ,
  output logic        HOLD,
  output logic [31:0] PC,
  output logic        ERR,
`ifdef PC_SEQ_PERF_EN
  output logic [31:0] RETIRED_CNT,
  output logic [31:0] TAKEN_CNT,
`endif
  output logic        HALTED
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_err;
  logic [7:0]  r_cnt;
  logic        r_halt_pend;

  logic [7:0]  w_cnt_inc;
  logic        w_misaligned;
  logic        w_halt;
  logic        w_taken;

  assign w_cnt_inc    = r_cnt + 8'd1;
  assign w_misaligned = |NEXT_PC[1:0];
  assign w_halt       = r_halt_pend | HALT_REQ;
  assign w_taken      = (NEXT_PC != (r_pc + 32'd4));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_RESET;
      r_pc        <= RESET_VECTOR;
      r_instr     <= 32'h0;
      r_err       <= 1'b0;
      r_cnt       <= 8'h0;
      r_halt_pend <= 1'b0;
    end else begin
      case (r_state)
        S_RESET: begin
          r_state <= S_FETCH;
          r_cnt   <= 8'h0;
        end
        S_FETCH: begin
          if (HALT_REQ) r_halt_pend <= 1'b1;
          if (IMEM_ACK) begin
            r_instr <= IMEM_DATA;
            r_cnt   <= 8'h0;
            r_state <= S_EXEC;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == TIMEOUT_C) begin
              r_err   <= 1'b1;
              r_state <= S_HALT;
            end
          end
        end
        S_EXEC: begin
          if (HALT_REQ) r_halt_pend <= 1'b1;
          if (EXEC_DONE) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          // A misaligned target never reaches the PC; the core stops with the old PC visible.
          if (w_misaligned) begin
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_pc        <= NEXT_PC;
            r_halt_pend <= 1'b0;
            r_state     <= w_halt ? S_HALT : S_FETCH;
          end
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_RESET;
      endcase
    end
  end

`ifdef PC_SEQ_PERF_EN
  logic [31:0] r_retired_cnt;
  logic [31:0] r_taken_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_retired_cnt <= 32'h0;
      r_taken_cnt   <= 32'h0;
    end else if (r_state == S_UPDATE && !w_misaligned) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
      if (w_taken) r_taken_cnt <= r_taken_cnt + 32'd1;
    end
  end

  assign RETIRED_CNT = r_retired_cnt;
  assign TAKEN_CNT   = r_taken_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = w_taken;
`endif

  assign IMEM_REQ    = (r_state == S_FETCH);
  assign IMEM_ADDR   = r_pc;
  assign INSTR       = r_instr;
  assign INSTR_VALID = (r_state == S_EXEC);
  assign HOLD        = (r_state != S_UPDATE);
  assign PC          = r_pc;
  assign ERR         = r_err;
  assign HALTED      = (r_state == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, taken branch, stalls, wrap, halt, reset, faults.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK = 1'b0;
  logic [31:0] IMEM_DATA = 32'h0;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic        EXEC_DONE = 1'b0;
  logic [31:0] NEXT_PC = 32'h0;
  logic        HALT_REQ = 1'b0;
  logic        HOLD;
  logic [31:0] PC;
  logic        ERR;
  logic        HALTED;
`ifdef PC_SEQ_PERF_EN
  logic [31:0] RETIRED_CNT;
  logic [31:0] TAKEN_CNT;
`endif

  pc_sequencer #(.RESET_VECTOR(RV), .ACK_TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .EXEC_DONE(EXEC_DONE),
    .NEXT_PC(NEXT_PC), .HALT_REQ(HALT_REQ), .HOLD(HOLD), .PC(PC), .ERR(ERR),
`ifdef PC_SEQ_PERF_EN
    .RETIRED_CNT(RETIRED_CNT), .TAKEN_CNT(TAKEN_CNT),
`endif
    .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          c0;
  logic [31:0] exp_pc;
  logic        exp_err;
  int unsigned exp_ret;
  int unsigned exp_taken;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", tag, got, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic check_perf();
`ifdef PC_SEQ_PERF_EN
    check32("retired_cnt", RETIRED_CNT, exp_ret);
    check32("taken_cnt", TAKEN_CNT, exp_taken);
`endif
  endtask

  // Assert RST for one edge from any state, check the reset state, then step into FETCH.
  task automatic do_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    IMEM_ACK = 1'b0;
    EXEC_DONE = 1'b0;
    HALT_REQ = 1'b0;
    exp_pc = RV; exp_err = 1'b0; exp_ret = 0; exp_taken = 0;
    check32("rst_pc", PC, RV);
    check32("rst_instr", INSTR, 32'h0);
    check32("rst_req", IMEM_REQ, 0);
    check32("rst_valid", INSTR_VALID, 0);
    check32("rst_hold", HOLD, 1);
    check32("rst_err", ERR, 0);
    check32("rst_halted", HALTED, 0);
    check_perf();
    tick();
  endtask

  // Entered in FETCH; leaves just after the UPDATE edge.
  task automatic run_instr(input logic [31:0] data, input logic [31:0] npc,
                           input int ack_wait, input int exec_wait, input logic halt_fetch);
    check32("fetch_req", IMEM_REQ, 1);
    check32("fetch_addr", IMEM_ADDR, exp_pc);
    check32("fetch_hold", HOLD, 1);
    HALT_REQ = halt_fetch;
    for (int i = 0; i < ack_wait; i++) begin
      tick();
      HALT_REQ = 1'b0;
      check32("fetch_wait_req", IMEM_REQ, 1);
      check32("fetch_wait_pc", PC, exp_pc);
    end
    IMEM_ACK = 1'b1;
    IMEM_DATA = data;
    tick();
    HALT_REQ = 1'b0;
    IMEM_ACK = 1'b0;
    IMEM_DATA = ~data;
    check32("exec_valid", INSTR_VALID, 1);
    check32("exec_instr", INSTR, data);
    check32("exec_hold", HOLD, 1);
    check32("exec_req", IMEM_REQ, 0);
    for (int i = 0; i < exec_wait; i++) begin
      tick();
      check32("exec_stall_instr", INSTR, data);
      check32("exec_stall_valid", INSTR_VALID, 1);
      check32("exec_stall_pc", PC, exp_pc);
    end
    EXEC_DONE = 1'b1;
    tick();
    EXEC_DONE = 1'b0;
    check32("upd_hold", HOLD, 0);
    check32("upd_valid", INSTR_VALID, 0);
    check32("upd_pc", PC, exp_pc);
    NEXT_PC = npc;
    tick();
    if (npc[1:0] != 2'b00) begin
      exp_err = 1'b1;
      check32("mis_pc", PC, exp_pc);
      check32("mis_err", ERR, 1);
      check32("mis_halted", HALTED, 1);
    end else begin
      exp_ret++;
      if (npc != exp_pc + 32'd4) exp_taken++;
      exp_pc = npc;
      check32("new_pc", PC, exp_pc);
      check32("post_halted", HALTED, {31'b0, halt_fetch});
      check32("post_err", ERR, {31'b0, exp_err});
    end
  endtask

  initial begin
    do_reset();

    // Zero-wait sequential flow with 3-cycle spacing, then a taken branch.
    c0 = cyc; run_instr(32'h1111_0001, 32'h4, 0, 0, 1'b0); check32("spacing0", cyc - c0, 3);
    c0 = cyc; run_instr(32'h1111_0002, 32'h8, 0, 0, 1'b0); check32("spacing1", cyc - c0, 3);
    run_instr(32'h1111_0003, 32'h40, 0, 0, 1'b0);
    check32("branch_addr", IMEM_ADDR, 32'h40);
    check_perf();

    // Stalled fetch and execute.
    run_instr(32'hCAFE_BABE, 32'h44, 2, 4, 1'b0);

    // Wrap through the top of the address space.
    run_instr(32'h2222_0001, 32'hFFFF_FFFC, 0, 0, 1'b0);
    run_instr(32'h2222_0002, 32'h0, 0, 0, 1'b0);

    // HALT_REQ seen only during FETCH still retires the instruction.
    run_instr(32'h3333_0001, 32'h4, 1, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check32("halt_stay", HALTED, 1);
      check32("halt_req", IMEM_REQ, 0);
      check32("halt_hold", HOLD, 1);
      check32("halt_pc", PC, 32'h4);
    end
    check_perf();

    // Reset in the middle of EXEC.
    do_reset();
    run_instr(32'h4444_0001, 32'h4, 0, 0, 1'b0);
    IMEM_ACK = 1'b1;
    IMEM_DATA = 32'h4444_0002;
    tick();
    IMEM_ACK = 1'b0;
    check32("midexec_valid", INSTR_VALID, 1);
    do_reset();

    // Misaligned target.
    run_instr(32'h5555_0001, 32'h4, 0, 0, 1'b0);
    run_instr(32'h5555_0002, 32'h42, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check32("mis_req_low", IMEM_REQ, 0);
      check32("mis_err_sticky", ERR, 1);
    end
    check_perf();

    // Fetch timeout after four unacknowledged FETCH cycles.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      check32("to_req", IMEM_REQ, 1);
      check32("to_halted", HALTED, 0);
    end
    tick();
    check32("to_err", ERR, 1);
    check32("to_halt", HALTED, 1);
    check32("to_req_low", IMEM_REQ, 0);
    do_reset();
    check32("final_pc", PC, RV);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
